// File: rtl/rf_wb_arbiter.sv
// Two-requester arbiter for the regfile write port, with read-port bypass.
// w0 (load writeback) is preferred; w1 (ALU writeback) is forced through after STARVE_LIMIT waits.
module rf_wb_arbiter #(
  parameter int DW           = 64,
  parameter int AW           = 5,
  parameter int ZERO_REG     = 31,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          w0_valid,
  output logic          w0_ready,
  input  logic [AW-1:0] w0_addr,
  input  logic [DW-1:0] w0_data,
  input  logic          w1_valid,
  output logic          w1_ready,
  input  logic [AW-1:0] w1_addr,
  input  logic [DW-1:0] w1_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  input  logic [DW-1:0] rf_rdata1,
  input  logic [DW-1:0] rf_rdata2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  output logic          force1
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW-1:0] ZADDR = AW'(ZERO_REG);

  typedef enum logic {NORMAL = 1'b0, FORCE = 1'b1} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          w0_acc, w1_acc;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  // Handshake: a requester's write is taken on a cycle where valid && ready.
  // Ready never depends on the requester's own valid; both are held low in rst.
  assign force1   = (state == FORCE);
  assign w0_ready = !rst && !force1;
  assign w1_ready = !rst && (force1 || !w0_valid);
  assign w0_acc   = w0_valid && w0_ready;
  assign w1_acc   = w1_valid && w1_ready;

  always_comb begin
    cnt_next   = '0;
    state_next = state;
    if (w1_valid && !w1_acc) cnt_next = cnt + CW'(1);
    case (state)
      NORMAL: if (cnt_next == CW'(STARVE_LIMIT)) state_next = FORCE;
      FORCE:  if (w1_acc || !w1_valid) state_next = NORMAL;
      default: state_next = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NORMAL;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    sel_addr = w0_addr;
    sel_data = w0_data;
    if (w1_acc) begin
      sel_addr = w1_addr;
      sel_data = w1_data;
    end
  end

  // Writes to the hardwired-zero register complete the handshake but never raise rf_we.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (w0_acc || w1_acc) begin
      rf_we    <= (sel_addr != ZADDR);
      rf_waddr <= sel_addr;
      rf_wdata <= sel_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

  always_comb begin
    rdata1 = rf_rdata1;
    if (rd_addr1 == ZADDR) rdata1 = '0;
    else if (rf_we && rd_addr1 == rf_waddr) rdata1 = rf_wdata;
  end

  always_comb begin
    rdata2 = rf_rdata2;
    if (rd_addr2 == ZADDR) rdata2 = '0;
    else if (rf_we && rd_addr2 == rf_waddr) rdata2 = rf_wdata;
  end

endmodule
